// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Tagged, direct-mapped branch target buffer for the fetch
//               stage. Combinational lookup on the fetch PC, trained by the
//               branch-resolution port (allocate-on-taken, saturating
//               direction counters, per-entry clear, full flush).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int unsigned NR_ENTRIES              = 8,
    parameter int unsigned BITS_SATURATION_COUNTER = 2,
    parameter int unsigned PC_WIDTH                = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] vpc_i,
    output logic                predict_valid_o,
    output logic                predict_taken_o,
    output logic [PC_WIDTH-1:0] predict_address_o,
    output logic                predict_is_lower_16_o,
    input  logic                bp_valid_i,
    input  logic [PC_WIDTH-1:0] bp_pc_i,
    input  logic [PC_WIDTH-1:0] bp_target_i,
    input  logic                bp_is_taken_i,
    input  logic                bp_is_mispredict_i,
    input  logic                bp_is_lower_16_i,
    input  logic                bp_clear_i
);

    localparam int unsigned c_IDX   = $clog2(NR_ENTRIES);
    localparam int unsigned c_TAG_W = PC_WIDTH - c_IDX - 2;
    localparam int unsigned c_B     = BITS_SATURATION_COUNTER;

    // Counter landmarks: allocation starts weakly taken, reset leaves the
    // counter weakly not-taken, and the top value saturates.
    localparam logic [c_B-1:0] c_CNT_ALLOC = c_B'(1) << (c_B - 1);
    localparam logic [c_B-1:0] c_CNT_RST   = c_CNT_ALLOC - c_B'(1);
    localparam logic [c_B-1:0] c_CNT_MAX   = '1;

    // Entry storage
    logic [NR_ENTRIES-1:0] valid_q, valid_d;
    logic [c_TAG_W-1:0]    tag_q    [NR_ENTRIES];
    logic [c_TAG_W-1:0]    tag_d    [NR_ENTRIES];
    logic [PC_WIDTH-1:0]   target_q [NR_ENTRIES];
    logic [PC_WIDTH-1:0]   target_d [NR_ENTRIES];
    logic                  lower_q  [NR_ENTRIES];
    logic                  lower_d  [NR_ENTRIES];
    logic [c_B-1:0]        cnt_q    [NR_ENTRIES];
    logic [c_B-1:0]        cnt_d    [NR_ENTRIES];

    // Index/tag split of the fetch PC and the update PC; bits [1:0] unused.
    logic [c_IDX-1:0]   w_look_idx, w_upd_idx;
    logic [c_TAG_W-1:0] w_look_tag, w_upd_tag;
    logic               w_look_hit, w_upd_hit;
    logic               w_unused;

    assign w_look_idx = vpc_i[c_IDX+1:2];
    assign w_look_tag = vpc_i[PC_WIDTH-1:c_IDX+2];
    assign w_upd_idx  = bp_pc_i[c_IDX+1:2];
    assign w_upd_tag  = bp_pc_i[PC_WIDTH-1:c_IDX+2];

    assign w_look_hit = valid_q[w_look_idx] && (tag_q[w_look_idx] == w_look_tag);
    assign w_upd_hit  = valid_q[w_upd_idx]  && (tag_q[w_upd_idx]  == w_upd_tag);

    // Mispredict flag is informational only; low PC bits never index or tag.
    assign w_unused = ^{bp_is_mispredict_i, vpc_i[1:0], bp_pc_i[1:0]};

    // Zero-latency prediction; every output is forced to 0 on a miss.
    assign predict_valid_o       = w_look_hit;
    assign predict_taken_o       = w_look_hit & cnt_q[w_look_idx][c_B-1];
    assign predict_address_o     = w_look_hit ? target_q[w_look_idx] : '0;
    assign predict_is_lower_16_o = w_look_hit & lower_q[w_look_idx];

    // Next-state: flush beats any update; clear, train-on-hit or allocate.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        lower_d  = lower_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (bp_valid_i) begin
            if (bp_clear_i) begin
                valid_d[w_upd_idx] = 1'b0;
            end else if (w_upd_hit) begin
                if (bp_is_taken_i) begin
                    if (cnt_q[w_upd_idx] != c_CNT_MAX) begin
                        cnt_d[w_upd_idx] = cnt_q[w_upd_idx] + c_B'(1);
                    end
                    target_d[w_upd_idx] = bp_target_i;
                    lower_d[w_upd_idx]  = bp_is_lower_16_i;
                end else if (cnt_q[w_upd_idx] != '0) begin
                    cnt_d[w_upd_idx] = cnt_q[w_upd_idx] - c_B'(1);
                end
            end else if (bp_is_taken_i) begin
                // Allocation replaces whatever occupies the slot.
                valid_d[w_upd_idx]  = 1'b1;
                tag_d[w_upd_idx]    = w_upd_tag;
                target_d[w_upd_idx] = bp_target_i;
                lower_d[w_upd_idx]  = bp_is_lower_16_i;
                cnt_d[w_upd_idx]    = c_CNT_ALLOC;
            end
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                lower_q[i]  <= 1'b0;
                cnt_q[i]    <= c_CNT_RST;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            lower_q  <= lower_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Self-checking bench for branch_target_buffer. Two instances
//               (default parameters, and 32 entries / 3-bit counter / 39-bit
//               PC) share stimulus and are compared against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush, bp_v, bp_t, bp_m, bp_lo, bp_clr;
    logic [63:0] vpc, bp_pc, bp_tgt;

    logic        a_pv, a_pt, a_pl;
    logic [63:0] a_pa;
    logic        b_pv, b_pt, b_pl;
    logic [38:0] b_pa;

    int errors = 0;
    int checks = 0;

    branch_target_buffer #(.NR_ENTRIES(8), .BITS_SATURATION_COUNTER(2), .PC_WIDTH(64)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vpc_i(vpc),
        .predict_valid_o(a_pv), .predict_taken_o(a_pt),
        .predict_address_o(a_pa), .predict_is_lower_16_o(a_pl),
        .bp_valid_i(bp_v), .bp_pc_i(bp_pc), .bp_target_i(bp_tgt),
        .bp_is_taken_i(bp_t), .bp_is_mispredict_i(bp_m),
        .bp_is_lower_16_i(bp_lo), .bp_clear_i(bp_clr)
    );

    branch_target_buffer #(.NR_ENTRIES(32), .BITS_SATURATION_COUNTER(3), .PC_WIDTH(39)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .vpc_i(vpc[38:0]),
        .predict_valid_o(b_pv), .predict_taken_o(b_pt),
        .predict_address_o(b_pa), .predict_is_lower_16_o(b_pl),
        .bp_valid_i(bp_v), .bp_pc_i(bp_pc[38:0]), .bp_target_i(bp_tgt[38:0]),
        .bp_is_taken_i(bp_t), .bp_is_mispredict_i(bp_m),
        .bp_is_lower_16_i(bp_lo), .bp_clear_i(bp_clr)
    );

    // ---------------- reference model: plain table of entries ----------------
    int          M_N [2] = '{8, 32};
    int          M_B [2] = '{2, 3};
    int          M_W [2] = '{64, 39};
    int          M_L [2] = '{3, 5};
    bit          m_v   [2][32];
    logic [63:0] m_tag [2][32];
    logic [63:0] m_tgt [2][32];
    bit          m_lo  [2][32];
    int          m_c   [2][32];

    function automatic logic [63:0] m_mask(int k);
        return (M_W[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << M_W[k]) - 64'd1);
    endfunction

    function automatic void m_reset(int k);
        for (int i = 0; i < 32; i++) begin
            m_v[k][i] = 0; m_tag[k][i] = '0; m_tgt[k][i] = '0; m_lo[k][i] = 0;
            m_c[k][i] = (2 ** (M_B[k] - 1)) - 1;
        end
    endfunction

    // Expected {valid, taken, lower16, address} for a lookup of pc.
    function automatic logic [66:0] m_look(int k, logic [63:0] pc);
        logic [63:0] p;
        int i;
        p = pc & m_mask(k);
        i = int'((p >> 2) % 64'(M_N[k]));
        if (m_v[k][i] && m_tag[k][i] == (p >> (M_L[k] + 2)))
            return {1'b1, (m_c[k][i] >= 2 ** (M_B[k] - 1)), m_lo[k][i], m_tgt[k][i]};
        return '0;
    endfunction

    function automatic void m_update(int k);
        logic [63:0] p, t;
        int i;
        bit hit;
        if (flush) begin
            for (int j = 0; j < 32; j++) m_v[k][j] = 0;
            return;
        end
        if (!bp_v) return;
        p   = bp_pc & m_mask(k);
        i   = int'((p >> 2) % 64'(M_N[k]));
        t   = p >> (M_L[k] + 2);
        hit = m_v[k][i] && (m_tag[k][i] == t);
        if (bp_clr) begin
            m_v[k][i] = 0;
        end else if (hit) begin
            if (bp_t) begin
                m_c[k][i]   = (m_c[k][i] + 1 > 2 ** M_B[k] - 1) ? 2 ** M_B[k] - 1 : m_c[k][i] + 1;
                m_tgt[k][i] = bp_tgt & m_mask(k);
                m_lo[k][i]  = bp_lo;
            end else begin
                m_c[k][i] = (m_c[k][i] == 0) ? 0 : m_c[k][i] - 1;
            end
        end else if (bp_t) begin
            m_v[k][i] = 1; m_tag[k][i] = t; m_tgt[k][i] = bp_tgt & m_mask(k);
            m_lo[k][i] = bp_lo; m_c[k][i] = 2 ** (M_B[k] - 1);
        end
    endfunction

    function automatic logic [66:0] obs(int k);
        if (k == 0) return {a_pv, a_pt, a_pl, a_pa};
        return {b_pv, b_pt, b_pl, 25'd0, b_pa};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                         input logic t, input logic lo, input logic clr, input logic fl,
                         input logic [63:0] look);
        bp_v = v; bp_pc = pc; bp_tgt = tgt; bp_t = t; bp_lo = lo; bp_clr = clr;
        flush = fl; vpc = look; bp_m = $urandom_range(0, 1);
    endtask

    task automatic idle(input logic [63:0] look);
        drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, look);
    endtask

    task automatic tick();
        @(posedge clk);
        m_update(0);
        m_update(1);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [66:0] o;
        rst = 1'b1;
        idle(64'h8000_0000);
        m_reset(0); m_reset(1);
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); checks++;
            if (o !== 67'd0) begin
                errors++; $display("FAIL reset_lookup inst%0d: got %h expected %h", k, o, 67'd0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alloc();
        logic [66:0] o, e;
        drive(1, 64'h8000_0010, 64'h8000_0100, 1, 1, 0, 0, 64'h8000_0010);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); e = m_look(k, vpc); checks++;
            if (o !== e) begin
                errors++; $display("FAIL alloc_no_bypass inst%0d: got %h expected %h", k, o, e);
            end
        end
        tick();
        idle(64'h8000_0010);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); checks++;
            if (o !== {1'b1, 1'b1, 1'b1, 64'h8000_0100}) begin
                errors++; $display("FAIL alloc_hit inst%0d: got %h expected %h", k, o,
                                   {1'b1, 1'b1, 1'b1, 64'h8000_0100});
            end
        end
        vpc = 64'h8000_0030;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); e = m_look(k, vpc); checks++;
            if (o !== e) begin
                errors++; $display("FAIL alloc_other_tag inst%0d: got %h expected %h", k, o, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit          seq  [26] = '{0,0,0, 1,1,1,1,1,1,1,1,1, 0,0,0,0, 0,0,0,0,0,0,0,0, 1,1};
        bit          expa [26] = '{0,0,0, 0,1,1,1,1,1,1,1,1, 1,0,0,0, 0,0,0,0,0,0,0,0, 0,1};
        logic [66:0] o, e;
        for (int i = 0; i < 26; i++) begin
            drive(1, 64'h8000_0010, 64'h9000_0000 + 64'(i * 4), seq[i], 1'(i), 0, 0, 64'h8000_0010);
            tick();
            idle(64'h8000_0010);
            #1;
            checks++;
            if (a_pt !== expa[i]) begin
                errors++; $display("FAIL sat_taken_a step%0d: got %b expected %b", i, a_pt, expa[i]);
            end
            for (int k = 0; k < 2; k++) begin
                o = obs(k); e = m_look(k, vpc); checks++;
                if (o !== e) begin
                    errors++; $display("FAIL sat_model inst%0d step%0d: got %h expected %h", k, i, o, e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_alias();
        logic [63:0] looks [4] = '{64'h8000_0030, 64'h8000_0010, 64'h0000_0000, 64'h0000_0080};
        logic [66:0] o, e;
        // Not-taken update to an empty slot must not allocate.
        drive(1, 64'h8000_0044, 64'h8000_0400, 0, 0, 0, 0, 64'h8000_0044);
        tick();
        idle(64'h8000_0044);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); checks++;
            if (o !== 67'd0) begin
                errors++; $display("FAIL nt_miss_noalloc inst%0d: got %h expected %h", k, o, 67'd0);
            end
        end
        // Alias replaces the occupant; then index wrap 0x80 vs 0x00.
        drive(1, 64'h8000_0030, 64'h8000_0200, 1, 0, 0, 0, 64'h8000_0030);
        tick();
        idle(64'h8000_0030);
        #1;
        checks++;
        if (obs(0) !== {1'b1, 1'b1, 1'b0, 64'h8000_0200}) begin
            errors++; $display("FAIL alias_replace inst0: got %h expected %h", obs(0),
                               {1'b1, 1'b1, 1'b0, 64'h8000_0200});
        end
        drive(1, 64'h0000_0080, 64'h0000_1234, 1, 1, 0, 0, 64'h0000_0080);
        tick();
        for (int j = 0; j < 4; j++) begin
            idle(looks[j]);
            #1;
            for (int k = 0; k < 2; k++) begin
                o = obs(k); e = m_look(k, vpc); checks++;
                if (o !== e) begin
                    errors++; $display("FAIL alias_wrap inst%0d pc=%h: got %h expected %h", k, vpc, o, e);
                end
            end
        end
        idle(64'h0000_0000);
        #1;
        checks++;
        if (b_pv !== 1'b0) begin
            errors++; $display("FAIL wrap_miss inst1: got %b expected 0", b_pv);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_flush();
        logic [66:0] o, e;
        drive(1, 64'h8000_0024, 64'h8000_0500, 1, 0, 0, 0, 64'h0);
        tick();
        drive(1, 64'h8000_0030, 64'h8000_0000, 1, 0, 1, 0, 64'h0);
        tick();
        idle(64'h8000_0030);
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); checks++;
            if (o !== 67'd0) begin
                errors++; $display("FAIL clear_miss inst%0d: got %h expected %h", k, o, 67'd0);
            end
        end
        vpc = 64'h8000_0024;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k); e = m_look(k, vpc); checks++;
            if (o !== e || o[66] !== 1'b1) begin
                errors++; $display("FAIL clear_neighbour inst%0d: got %h expected %h", k, o, e);
            end
        end
        // Flush together with an allocation: nothing survives.
        drive(1, 64'h8000_0008, 64'h8000_0800, 1, 1, 0, 1, 64'h8000_0008);
        tick();
        idle(64'h8000_0008);
        #1;
        checks++;
        if ({a_pv, b_pv} !== 2'b00) begin
            errors++; $display("FAIL flush_alloc: got %b expected 00", {a_pv, b_pv});
        end
        vpc = 64'h8000_0024;
        #1;
        checks++;
        if ({a_pv, b_pv} !== 2'b00) begin
            errors++; $display("FAIL flush_all: got %b expected 00", {a_pv, b_pv});
        end
        // Asynchronous reset between edges.
        drive(1, 64'h8000_0010, 64'h8000_0100, 1, 0, 0, 0, 64'h0);
        tick();
        idle(64'h8000_0010);
        #1;
        checks++;
        if ({a_pv, b_pv} !== 2'b11) begin
            errors++; $display("FAIL pre_reset_hit: got %b expected 11", {a_pv, b_pv});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_pv, b_pv} !== 2'b00) begin
            errors++; $display("FAIL async_reset: got %b expected 00", {a_pv, b_pv});
        end
        m_reset(0); m_reset(1);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [66:0] o, e;
        logic [63:0] pc, look;
        for (int n = 0; n < 400; n++) begin
            pc   = 64'h8000_0000 + (64'($urandom_range(0, 3)) << 7)
                 + (64'($urandom_range(0, 31)) << 2) + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pc = pc | 64'h0000_0100_0000_0000;
            look = 64'h8000_0000 + (64'($urandom_range(0, 3)) << 7)
                 + (64'($urandom_range(0, 31)) << 2);
            drive($urandom_range(0, 9) < 7, pc, 64'({$urandom(), $urandom()}),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 1),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, look);
            #1;
            for (int k = 0; k < 2; k++) begin
                o = obs(k); e = m_look(k, vpc); checks++;
                if (o !== e) begin
                    errors++; $display("FAIL random inst%0d cyc%0d pc=%h: got %h expected %h",
                                       k, n, vpc, o, e);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle(64'h0);
        test_reset();
        test_alloc();
        test_saturation();
        test_alias();
        test_clear_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
